// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the paced display scheduler.
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    CAPT  = 2'd2,
    APPLY = 2'd3
  } state_e;

  // What APPLY does with the captured byte.
  typedef enum logic [1:0] {
    OP_SHL  = 2'd0,
    OP_SHR  = 2'd1,
    OP_CLR  = 2'd2,
    OP_DROP = 2'd3
  } op_e;

  localparam logic [7:0] CMD_BS     = 8'h08;
  localparam logic [7:0] CMD_CLR    = 8'h0C;
  localparam logic [7:0] HEX_MAX    = 8'h0F;
  localparam logic [4:0] BLANK_CODE = 5'd20;

  // Command codes sit inside the hex range, so they are matched first.
  function automatic op_e decode_byte(input logic [7:0] b);
    op_e op;
    case (b)
      CMD_BS:  op = OP_SHR;
      CMD_CLR: op = OP_CLR;
      default: op = (b <= HEX_MAX) ? OP_SHL : OP_DROP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/display_sched_pace_tick.sv
// Free-running divider producing a registered 1-clk tick every TICK_DIV clocks.
module pace_tick #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and tick: wrap at terminal count, flag it for one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/display_sched.sv
// Paced consumer of the SPI receive FIFO: pops one byte per pacing tick,
// decodes it and scrolls hex digits into a 6-digit bank for seven_seg.
// Optional macro DISP_SCHED_ERRCNT_EN adds err_cnt, a saturating count of
// discarded (unrecognised) bytes.
module display_sched
  import disp_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter logic [4:0]  BLANK    = BLANK_CODE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  input  logic       hold,
  input  logic       clear,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic [4:0] digit4,
  output logic [4:0] digit5,
`ifdef DISP_SCHED_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       busy
);

  logic       tick_s;
  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       tick_pend_q, tick_pend_d;
  logic       fifo_rd_q, fifo_rd_d;
  logic       busy_q, busy_d;
  logic [4:0] digit_q [6];
  logic [4:0] digit_d [6];
`ifdef DISP_SCHED_ERRCNT_EN
  logic [7:0] err_q, err_d;
`endif

  pace_tick #(.TICK_DIV(TICK_DIV)) u_pace_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Sequencer next state, byte capture, digit update and pacing bookkeeping.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    digit_d = digit_q;
`ifdef DISP_SCHED_ERRCNT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick_pend_q && !fifo_empty && !hold) begin
          state_d = POP;
        end else begin
          state_d = IDLE;
        end
      end
      POP: state_d = CAPT;
      CAPT: begin
        byte_d  = fifo_dout;
        state_d = APPLY;
      end
      APPLY: begin
        state_d = IDLE;
        case (decode_byte(byte_q))
          OP_SHL: begin
            for (int i = 5; i > 0; i--) digit_d[i] = digit_q[i-1];
            digit_d[0] = {1'b0, byte_q[3:0]};
          end
          OP_SHR: begin
            for (int i = 0; i < 5; i++) digit_d[i] = digit_q[i+1];
            digit_d[5] = BLANK;
          end
          OP_CLR: begin
            for (int i = 0; i < 6; i++) digit_d[i] = BLANK;
          end
          default: begin
`ifdef DISP_SCHED_ERRCNT_EN
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end else begin
              err_d = err_q;
            end
`endif
          end
        endcase
      end
      default: state_d = IDLE;
    endcase

    // clear overrides whatever APPLY decided this cycle.
    if (clear) begin
      for (int i = 0; i < 6; i++) digit_d[i] = BLANK;
`ifdef DISP_SCHED_ERRCNT_EN
      err_d = 8'd0;
`endif
    end else begin
      digit_d = digit_d;
    end

    // Ticks merge while pending; the pending flag is consumed on POP entry.
    if ((state_q == IDLE) && (state_d == POP)) begin
      tick_pend_d = 1'b0;
    end else begin
      tick_pend_d = tick_pend_q | tick_s;
    end

    // Outputs are registered copies of the state being entered.
    fifo_rd_d = (state_d == POP);
    busy_d    = (state_d != IDLE);
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      tick_pend_q <= 1'b0;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 6; i++) digit_q[i] <= BLANK;
`ifdef DISP_SCHED_ERRCNT_EN
      err_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      tick_pend_q <= tick_pend_d;
      fifo_rd_q   <= fifo_rd_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 6; i++) digit_q[i] <= digit_d[i];
`ifdef DISP_SCHED_ERRCNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign fifo_rd = fifo_rd_q;
  assign busy    = busy_q;
  assign digit0  = digit_q[0];
  assign digit1  = digit_q[1];
  assign digit2  = digit_q[2];
  assign digit3  = digit_q[3];
  assign digit4  = digit_q[4];
  assign digit5  = digit_q[5];
`ifdef DISP_SCHED_ERRCNT_EN
  assign err_cnt = err_q;
`endif

endmodule
